// File: rtl/display_scroll_if.sv
// Host-side and display-side signal bundle for the scrolling message controller.
// The host/display driver uses the master view and the controller uses the slave view.
interface display_scroll_if;
   logic       wr_en;
   logic [4:0] wr_data;
   logic       clr;
   logic       run;
   logic [4:0] disp_data;
   logic [1:0] disp_pos;
   logic       disp_load;
   logic [4:0] msg_len;
   logic       full;
   logic       busy;

   modport master (
      output wr_en, wr_data, clr, run,
      input  disp_data, disp_pos, disp_load, msg_len, full, busy
   );

   modport slave (
      input  wr_en, wr_data, clr, run,
      output disp_data, disp_pos, disp_load, msg_len, full, busy
   );
endinterface

// File: rtl/display_scroll_controller.sv
// Scrolls a 16-entry character message across a 4-position display, one step per tick.
// Optional macro SCROLL_BLANK_GAP_EN inserts one blank between message repeats.
module display_scroll_controller #(
   parameter logic [23:0] TICK_DIV   = 24'd10_000_000,
   parameter int          MSG_DEPTH  = 16,
   parameter logic [4:0]  BLANK_CODE = 5'h1F
) (
   input logic             clk,
   input logic             rst_n,
   display_scroll_if.slave bus
);

   localparam logic [4:0] LEN_MAX = 5'(MSG_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      ADV
   } state_t;

   logic [4:0]  mem [MSG_DEPTH];
   logic [23:0] tick_cnt_reg;
   logic        tick;
   logic [4:0]  msg_len_reg;
   logic        full;
   logic        wr_fire;

   state_t      state_reg;
   logic [4:0]  offset_reg;
   logic [4:0]  idx_reg;
   logic [4:0]  len_reg;
   logic        disp_load_reg;
   logic [1:0]  disp_pos_reg;
   logic [4:0]  disp_data_reg;
   logic        busy_reg;

   logic [4:0]  rd_idx;
   logic [4:0]  rd_n;
   logic [4:0]  rd_char;

   // Effective scroll length for a stored character count.
   function automatic logic [4:0] eff_len(input logic [4:0] n);
`ifdef SCROLL_BLANK_GAP_EN
      return n + 5'd1;
`else
      return n;
`endif
   endfunction

   function automatic logic [4:0] next_idx(input logic [4:0] idx, input logic [4:0] l);
      return (idx == l - 5'd1) ? 5'd0 : idx + 5'd1;
   endfunction

   assign full    = (msg_len_reg == LEN_MAX);
   assign wr_fire = bus.wr_en && !full && !bus.clr;
   assign tick    = bus.run && (tick_cnt_reg == TICK_DIV - 24'd1);

   // Step-period counter; held at zero while scrolling is disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt_reg <= 24'd0;
      end else if (!bus.run) begin
         tick_cnt_reg <= 24'd0;
      end else if (tick_cnt_reg == TICK_DIV - 24'd1) begin
         tick_cnt_reg <= 24'd0;
      end else begin
         tick_cnt_reg <= tick_cnt_reg + 24'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         msg_len_reg <= 5'd0;
      end else if (bus.clr) begin
         msg_len_reg <= 5'd0;
      end else if (wr_fire) begin
         msg_len_reg <= msg_len_reg + 5'd1;
      end
   end

   // Message storage is deliberately left out of reset; msg_len gates visibility.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[msg_len_reg[3:0]] <= bus.wr_data;
      end
   end

   // IDLE reads the first character at the live length; LOAD uses the length latched on entry.
   always_comb begin
      rd_idx = idx_reg;
      rd_n   = len_reg;
      if (state_reg == IDLE) begin
         rd_idx = offset_reg;
         rd_n   = msg_len_reg;
      end
      // Any index at or past the stored count is the virtual blank slot.
      rd_char = (rd_idx >= rd_n) ? BLANK_CODE : mem[rd_idx[3:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         offset_reg    <= 5'd0;
         idx_reg       <= 5'd0;
         len_reg       <= 5'd0;
         disp_load_reg <= 1'b0;
         disp_pos_reg  <= 2'd0;
         disp_data_reg <= BLANK_CODE;
         busy_reg      <= 1'b0;
      end else if (bus.clr) begin
         state_reg     <= IDLE;
         offset_reg    <= 5'd0;
         idx_reg       <= 5'd0;
         len_reg       <= 5'd0;
         disp_load_reg <= 1'b0;
         disp_pos_reg  <= 2'd0;
         disp_data_reg <= BLANK_CODE;
         busy_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (tick && (msg_len_reg != 5'd0)) begin
                  state_reg     <= LOAD;
                  busy_reg      <= 1'b1;
                  disp_load_reg <= 1'b1;
                  disp_pos_reg  <= 2'd0;
                  disp_data_reg <= rd_char;
                  len_reg       <= msg_len_reg;
                  idx_reg       <= next_idx(offset_reg, eff_len(msg_len_reg));
               end
            end
            LOAD: begin
               if (disp_pos_reg == 2'd3) begin
                  state_reg     <= ADV;
                  disp_load_reg <= 1'b0;
                  disp_pos_reg  <= 2'd0;
                  disp_data_reg <= BLANK_CODE;
               end else begin
                  disp_pos_reg  <= disp_pos_reg + 2'd1;
                  disp_data_reg <= rd_char;
                  idx_reg       <= next_idx(idx_reg, eff_len(len_reg));
               end
            end
            ADV: begin
               offset_reg <= next_idx(offset_reg, eff_len(len_reg));
               state_reg  <= IDLE;
               busy_reg   <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.disp_data = disp_data_reg;
   assign bus.disp_pos  = disp_pos_reg;
   assign bus.disp_load = disp_load_reg;
   assign bus.msg_len   = msg_len_reg;
   assign bus.full      = full;
   assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_display_scroll_controller.sv
// Directed, table-driven bench for display_scroll_controller with a small scroll model.
module tb_display_scroll_controller;

   localparam logic [23:0] TDIV  = 24'd8;
   localparam int          BLANK = 31;
`ifdef SCROLL_BLANK_GAP_EN
   localparam int          GAP   = 1;
`else
   localparam int          GAP   = 0;
`endif

   typedef struct {
      logic       wr_en;
      logic [4:0] wr_data;
      logic       clr;
      logic [4:0] exp_len;
      logic       exp_full;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   display_scroll_if bus ();

   display_scroll_controller #(
      .TICK_DIV  (TDIV),
      .MSG_DEPTH (16),
      .BLANK_CODE(5'h1F)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   vec_t vecs [24];
   int   checks = 0;
   int   errors = 0;
   int   last_wait = 0;
   int   seen17 = 0;
   int   model_mem [16];
   int   model_len = 0;
   int   model_off = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int exp_char(input int idx);
      if (idx >= model_len) return BLANK;
      return model_mem[idx];
   endfunction

   task automatic model_clear();
      model_len = 0;
      model_off = 0;
   endtask

   task automatic model_write(input int code);
      if (model_len < 16) begin
         model_mem[model_len] = code;
         model_len++;
      end
   endtask

   task automatic do_write(input int code);
      bus.wr_en   = 1'b1;
      bus.wr_data = 5'(code);
      @(negedge clk);
      bus.wr_en = 1'b0;
      model_write(code);
   endtask

   task automatic apply_vectors(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         bus.wr_en   = vecs[i].wr_en;
         bus.wr_data = vecs[i].wr_data;
         bus.clr     = vecs[i].clr;
         @(negedge clk);
         check($sformatf("vec%0d_len", i), int'(bus.msg_len), int'(vecs[i].exp_len));
         check($sformatf("vec%0d_full", i), int'(bus.full), int'(vecs[i].exp_full));
         if (vecs[i].clr) model_clear();
         else if (vecs[i].wr_en) model_write(int'(vecs[i].wr_data));
         $display("vec %0d wr=%0b data=%0d clr=%0b -> len=%0d full=%0b", i, vecs[i].wr_en,
                  vecs[i].wr_data, vecs[i].clr, bus.msg_len, bus.full);
      end
      bus.wr_en = 1'b0;
      bus.clr   = 1'b0;
   endtask

   task automatic wait_load(output bit found);
      int n;
      found = 1'b0;
      n = 0;
      while (n < 40 && !found) begin
         @(negedge clk);
         n++;
         if (bus.disp_load === 1'b1) found = 1'b1;
      end
      last_wait = n;
      check("load_seen", found ? 1 : 0, 1);
   endtask

   task automatic get_seq(input string tag, input bit drop_run);
      bit found;
      int l, idx;
      int got [4];
      wait_load(found);
      if (!found) return;
      l   = model_len + GAP;
      idx = model_off;
      for (int p = 0; p < 4; p++) begin
         if (p > 0) @(negedge clk);
         if (p == 0 && drop_run) bus.run = 1'b0;
         got[p] = int'(bus.disp_data);
         if (bus.disp_data == 5'd17) seen17++;
         check({tag, "_load"}, int'(bus.disp_load), 1);
         check({tag, "_pos"}, int'(bus.disp_pos), p);
         check({tag, "_data"}, int'(bus.disp_data), exp_char(idx));
         check({tag, "_busy"}, int'(bus.busy), 1);
         idx = (idx == l - 1) ? 0 : idx + 1;
      end
      @(negedge clk);
      check({tag, "_adv_load"}, int'(bus.disp_load), 0);
      check({tag, "_adv_busy"}, int'(bus.busy), 1);
      check({tag, "_adv_data"}, int'(bus.disp_data), BLANK);
      @(negedge clk);
      check({tag, "_idle_busy"}, int'(bus.busy), 0);
      $display("seq %s off=%0d len=%0d data=%0d,%0d,%0d,%0d", tag, model_off, model_len,
               got[0], got[1], got[2], got[3]);
      model_off = (model_off == l - 1) ? 0 : model_off + 1;
   endtask

   initial begin
      bit found;
      int loads;

      for (int i = 0; i < 17; i++)
         vecs[i] = '{1'b1, 5'(i + 1), 1'b0, 5'((i + 1 > 16) ? 16 : i + 1), (i >= 15)};
      vecs[17] = '{1'b0, 5'd0, 1'b1, 5'd0, 1'b0};
      vecs[18] = '{1'b1, 5'd9, 1'b1, 5'd0, 1'b0};
      for (int i = 0; i < 5; i++)
         vecs[19 + i] = '{1'b1, 5'(i + 1), 1'b0, 5'(i + 1), 1'b0};

      bus.wr_en = 1'b0;
      bus.wr_data = 5'd0;
      bus.clr = 1'b0;
      bus.run = 1'b0;
      model_clear();

      repeat (3) @(negedge clk);
      check("rst_load", int'(bus.disp_load), 0);
      check("rst_pos", int'(bus.disp_pos), 0);
      check("rst_data", int'(bus.disp_data), BLANK);
      check("rst_len", int'(bus.msg_len), 0);
      check("rst_full", int'(bus.full), 0);
      check("rst_busy", int'(bus.busy), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Fill past capacity, then scroll the full buffer through a complete wrap.
      apply_vectors(0, 16);
      bus.run = 1'b1;
      for (int s = 0; s < 17; s++) get_seq($sformatf("full%0d", s), 1'b0);
      bus.run = 1'b0;
      check("code17_seen", seen17, 0);
      @(negedge clk);

      // Clear, clear-beats-write, then the five-character message.
      apply_vectors(17, 23);
      @(negedge clk);
      bus.run = 1'b1;
      get_seq("five0", 1'b0);
      check("first_latency", last_wait, 8);
      get_seq("five1", 1'b0);
      get_seq("five2", 1'b0);
      bus.run = 1'b0;
      @(negedge clk);

      // Single-character message; run dropped mid-sequence must not abort it.
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      model_clear();
      do_write(7);
      check("one_len", int'(bus.msg_len), 1);
      bus.run = 1'b1;
      get_seq("one0", 1'b1);
      bus.run = 1'b1;
      get_seq("one1", 1'b0);

      // Clear in the second load cycle.
      wait_load(found);
      if (found) begin
         @(negedge clk);
         check("clr_pre_load", int'(bus.disp_load), 1);
         check("clr_pre_pos", int'(bus.disp_pos), 1);
         bus.clr = 1'b1;
         @(negedge clk);
         bus.clr = 1'b0;
         model_clear();
         check("clr_load", int'(bus.disp_load), 0);
         check("clr_len", int'(bus.msg_len), 0);
         check("clr_busy", int'(bus.busy), 0);
         check("clr_data", int'(bus.disp_data), BLANK);
         loads = 0;
         for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.disp_load === 1'b1) loads++;
         end
         check("clr_no_loads", loads, 0);
         do_write(9);
         get_seq("after_clr", 1'b0);
      end

      // Asynchronous reset in the second load cycle, between clock edges.
      wait_load(found);
      if (found) begin
         @(negedge clk);
         #2 rst_n = 1'b0;
         #1;
         check("arst_load", int'(bus.disp_load), 0);
         check("arst_pos", int'(bus.disp_pos), 0);
         check("arst_data", int'(bus.disp_data), BLANK);
         check("arst_busy", int'(bus.busy), 0);
         check("arst_len", int'(bus.msg_len), 0);
         check("arst_full", int'(bus.full), 0);
         bus.run = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         model_clear();
         @(negedge clk);
         do_write(3);
         do_write(4);
         bus.run = 1'b1;
         get_seq("after_rst", 1'b0);
      end
      bus.run = 1'b0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
